// File: rtl/multicycle_maindec_pkg.sv
// Shared constants for the multicycle MIPS main decoder: opcodes, FSM state
// encodings, ALU operation codes and the control word driven to the datapath.
package multicycle_maindec_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRIMM  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Codes 13..15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ORIEX   = 4'd10,
    S_IMMWB   = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       branchne;
    logic       irwrite;
    logic       memwrite;
    logic       iord;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zext;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J: return 1'b1;
      default:                                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/maindec_outlogic.sv
// Combinational state -> control-word ROM. Only the BRANCH row looks at op,
// to choose between the beq and bne branch qualifiers.
module maindec_outlogic
  import multicycle_maindec_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] op_i,
  output ctrl_t      ctrl_o
);

  // Per-state control word; anything not set for a state stays 0.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.alusrcb = SRCB_FOUR;
        ctrl_o.irwrite = 1'b1;
        ctrl_o.pcwrite = 1'b1;
      end
      S_DECODE: ctrl_o.alusrcb = SRCB_BRIMM;
      S_MEMADR: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
      end
      S_MEMRD: ctrl_o.iord = 1'b1;
      S_MEMWB: begin
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.regdst   = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alusrca  = 1'b1;
        ctrl_o.aluop    = ALUOP_SUB;
        ctrl_o.pcsrc    = PCSRC_ALUOUT;
        ctrl_o.branch   = (op_i == OP_BEQ);
        ctrl_o.branchne = (op_i == OP_BNE);
      end
      S_ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
      end
      S_ORIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.zext    = 1'b1;
        ctrl_o.aluop   = ALUOP_OR;
      end
      S_IMMWB: ctrl_o.regwrite = 1'b1;
      S_JUMP: begin
        ctrl_o.pcsrc   = PCSRC_JUMP;
        ctrl_o.pcwrite = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_maindec.sv
// Main control FSM of the multicycle MIPS datapath: state register, next-state
// decode, illegal-opcode pulse and the zero-qualified PC enable.
module multicycle_maindec
  import multicycle_maindec_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zext,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal_op
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_s;

  // State register; reset lands in FETCH without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state decode and the DECODE-cycle illegal opcode flag.
  always_comb begin
    state_d    = S_FETCH;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXECUTE;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_ORI:         state_d = S_ORIEX;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_FETCH;
        endcase
        illegal_op = ~op_supported(op);
      end
      S_MEMADR: begin
        if (op == OP_LW) state_d = S_MEMRD;
        else             state_d = S_MEMWR;
      end
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_IMMWB;
      S_ORIEX:   state_d = S_IMMWB;
      default:   state_d = S_FETCH;
    endcase
  end

  maindec_outlogic u_outlogic (
    .state_i (state_q),
    .op_i    (op),
    .ctrl_o  (ctrl_s)
  );

  assign pcen     = ctrl_s.pcwrite | (ctrl_s.branch & zero) | (ctrl_s.branchne & ~zero);
  assign irwrite  = ctrl_s.irwrite;
  assign memwrite = ctrl_s.memwrite;
  assign iord     = ctrl_s.iord;
  assign regwrite = ctrl_s.regwrite;
  assign regdst   = ctrl_s.regdst;
  assign memtoreg = ctrl_s.memtoreg;
  assign alusrca  = ctrl_s.alusrca;
  assign alusrcb  = ctrl_s.alusrcb;
  assign zext     = ctrl_s.zext;
  assign pcsrc    = ctrl_s.pcsrc;
  assign aluop    = ctrl_s.aluop;

endmodule

// File: tb/tb_multicycle_maindec.sv
// Randomized bench for multicycle_maindec: a per-instruction step model predicts
// the full control word each cycle from opcode, step number and zero.
module tb_multicycle_maindec;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       zext, illegal_op;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_maindec dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .zero       (zero),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .iord       (iord),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .zext       (zext),
    .pcsrc      (pcsrc),
    .aluop      (aluop),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] observed();
    return {pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg, alusrca,
            alusrcb, zext, pcsrc, aluop, illegal_op};
  endfunction

  function automatic int cycles_for(input logic [5:0] o);
    case (o)
      6'b100011:                       return 5;
      6'b101011, 6'b000000,
      6'b001000, 6'b001101:            return 4;
      6'b000100, 6'b000101, 6'b000010: return 3;
      default:                         return 2;
    endcase
  endfunction

  // Expected control word for step k (0 = fetch, 1 = decode) of instruction o.
  function automatic logic [15:0] expected(input logic [5:0] o, input int k, input logic z);
    logic pc_en = 1'b0, irw = 1'b0, mw = 1'b0, ad = 1'b0, rw = 1'b0, rd = 1'b0;
    logic m2r = 1'b0, sa = 1'b0, zx = 1'b0, ill = 1'b0;
    logic [1:0] sb = 2'd0, ps = 2'd0, ao = 2'd0;
    if (k == 0) begin
      sb = 2'b01; irw = 1'b1; pc_en = 1'b1;
    end else if (k == 1) begin
      sb  = 2'b11;
      ill = (cycles_for(o) == 2);
    end else begin
      case (o)
        6'b100011: if (k == 2) begin sa = 1'b1; sb = 2'b10; end
                   else if (k == 3) ad = 1'b1;
                   else begin m2r = 1'b1; rw = 1'b1; end
        6'b101011: if (k == 2) begin sa = 1'b1; sb = 2'b10; end
                   else begin ad = 1'b1; mw = 1'b1; end
        6'b000000: if (k == 2) begin sa = 1'b1; ao = 2'b10; end
                   else begin rd = 1'b1; rw = 1'b1; end
        6'b000100: begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pc_en = z; end
        6'b000101: begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pc_en = ~z; end
        6'b001000: if (k == 2) begin sa = 1'b1; sb = 2'b10; end
                   else rw = 1'b1;
        6'b001101: if (k == 2) begin sa = 1'b1; sb = 2'b10; zx = 1'b1; ao = 2'b11; end
                   else rw = 1'b1;
        6'b000010: begin ps = 2'b10; pc_en = 1'b1; end
        default:   ill = 1'b0;
      endcase
    end
    return {pc_en, irw, mw, ad, rw, rd, m2r, sa, sb, zx, ps, ao, ill};
  endfunction

  // Entered at a negedge with the DUT in step k_first; leaves at the negedge after k_last.
  task automatic run_instr(input logic [5:0] o, input int k_first, input int k_last,
                           input int zforce);
    for (int k = k_first; k <= k_last; k++) begin
      op   = o;
      zero = (zforce < 0) ? 1'($urandom_range(0, 1)) : 1'(zforce);
      #1;
      check_eq($sformatf("op%02h_k%0d_z%0d", o, k, zero), observed(), expected(o, k, zero));
      @(negedge clk);
    end
  endtask

  logic [5:0] directed [12];
  int         dir_z    [12];
  logic [5:0] legal    [8];

  initial begin
    directed = '{6'b100011, 6'b000000, 6'b000100, 6'b000100, 6'b000101, 6'b000101,
                 6'b001101, 6'b111111, 6'b101011, 6'b001000, 6'b000010, 6'b000100};
    dir_z    = '{-1, -1, 1, 0, 1, 0, -1, -1, -1, -1, -1, -1};
    legal    = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                 6'b000101, 6'b001000, 6'b001101, 6'b000010};

    reset = 1'b1;
    op    = 6'b000000;
    zero  = 1'b0;
    #2;
    check_eq("reset_fetch", observed(), expected(6'b000000, 0, 1'b0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // R-type interrupted by reset while in EXECUTE.
    run_instr(6'b000000, 0, 1, -1);
    zero = 1'b1;
    #1;
    check_eq("pre_reset_execute", observed(), expected(6'b000000, 2, 1'b1));
    #1 reset = 1'b1;
    #1;
    check_eq("mid_reset_async", observed(), expected(6'b000000, 0, 1'b1));
    @(negedge clk);
    check_eq("mid_reset_held", observed(), expected(6'b000000, 0, 1'b1));
    reset = 1'b0;
    run_instr(6'b000000, 0, 3, -1);

    foreach (directed[i]) run_instr(directed[i], 0, cycles_for(directed[i]) - 1, dir_z[i]);

    for (int n = 0; n < 200; n++) begin
      logic [5:0] o;
      if ($urandom_range(0, 3) != 0) o = legal[$urandom_range(0, 7)];
      else                           o = 6'($urandom);
      run_instr(o, 0, cycles_for(o) - 1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
